// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back merge unit.
// wb_req_t carries a register index plus a WB_XLEN-bit result.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_XLEN    = 32;
    localparam int MAX_CH     = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_id;
        logic [WB_XLEN-1:0]    data;
    } wb_req_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping within nch channels.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] mask,
                                         input logic [2:0]        ptr,
                                         input int                nch);
        rr_pick_t pick;
        int       j;
        pick = '0;
        j    = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < nch) begin
                j = (int'(ptr) + i) % nch;
                if (mask[j[2:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = j[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_merge_unit_fifo.sv
// Per-channel result FIFO with a saturating head-age counter.
// starved is raised once the current head has waited STARVE_LIM cycles.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic    clk_sys,
    input  logic    rst_b,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty,
    output logic    starved
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIM + 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign starved = ~empty & (age >= AGE_W'(STARVE_LIM));
    assign wr_en   = push & ~full;
    assign rd_en   = pop & ~empty;

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            age    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A freshly exposed head always starts at age 0.
            if (empty | rd_en) begin
                age <= '0;
            end else if (age < AGE_W'(STARVE_LIM)) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_merge_unit.sv
// Write-back merge: in-order result has priority, long-latency results drain
// through per-channel FIFOs. Define WB_INSTRET_EN to add the retire counter.
module wb_merge_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int NCH        = 2,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [XLEN-1:0]            MW_PC_i,
    input  logic [31:0]                MW_instr_i,
    input  logic                       MW_nop_i,
    input  logic [REG_ADDR_W-1:0]      MW_rdId_i,
    input  logic [XLEN-1:0]            MW_wbData_i,
    input  logic                       MW_wbEnable_i,
    input  logic [NCH-1:0]             lu_valid_i,
    input  logic [NCH*REG_ADDR_W-1:0]  lu_rdId_i,
    input  logic [NCH*XLEN-1:0]        lu_data_i,
    output logic [NCH-1:0]             lu_ready_o,
    output logic                       stall_o,
    output logic                       rdWe_o,
    output logic [REG_ADDR_W-1:0]      rdId_o,
    output logic [XLEN-1:0]            rdData_o,
    output logic                       retire_o,
`ifdef WB_INSTRET_EN
    input  logic                       instretLoad_i,
    input  logic [63:0]                instretData_i,
    output logic [63:0]                instret_o,
`endif
    output logic [NCH-1:0]             pending_o
);

    logic [NCH-1:0] ch_push;
    logic [NCH-1:0] ch_pop;
    logic [NCH-1:0] ch_full;
    logic [NCH-1:0] ch_empty;
    logic [NCH-1:0] ch_starved;
    wb_req_t        ch_head [NCH];

    logic           stall;
    logic           mw_req;
    logic           ch_grant;
    logic           grant_vld;
    wb_req_t        grant_req;
    int             sel;
    rr_pick_t       pick;
    logic [2:0]     rr_ptr;
    logic [2:0]     rr_ptr_nxt;

    // PC and instruction word travel with the bundle but are not needed here.
    logic unused_mw;
    assign unused_mw = ^{MW_PC_i, MW_instr_i};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wb_req_t push_req;
        assign push_req.rd_id = lu_rdId_i[c*REG_ADDR_W +: REG_ADDR_W];
        assign push_req.data  = WB_XLEN'(lu_data_i[c*XLEN +: XLEN]);
        assign ch_push[c]     = lu_valid_i[c] & ~ch_full[c];

        wb_fifo #(
            .DEPTH      (DEPTH),
            .STARVE_LIM (STARVE_LIM)
        ) u_fifo (
            .clk_sys   (clk_i),
            .rst_b     (reset_i),
            .push      (ch_push[c]),
            .push_data (push_req),
            .pop       (ch_pop[c]),
            .head      (ch_head[c]),
            .full      (ch_full[c]),
            .empty     (ch_empty[c]),
            .starved   (ch_starved[c])
        );
    end

    assign stall      = (|ch_starved) & ~MW_nop_i;
    assign stall_o    = stall;
    assign lu_ready_o = ~ch_full;
    assign pending_o  = ~ch_empty;

    always_comb begin
        mw_req     = ~MW_nop_i & MW_wbEnable_i & ~stall;
        pick       = rr_pick(MAX_CH'(~ch_empty), rr_ptr, NCH);
        ch_pop     = '0;
        ch_grant   = 1'b0;
        grant_vld  = 1'b0;
        grant_req  = '0;
        rr_ptr_nxt = rr_ptr;
        sel        = 0;
        if (|ch_starved) begin
            ch_grant = 1'b1;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (ch_starved[c]) begin
                    sel = c;
                end
            end
        end else if (mw_req) begin
            grant_vld       = 1'b1;
            grant_req.rd_id = MW_rdId_i;
            grant_req.data  = WB_XLEN'(MW_wbData_i);
        end else if (pick.found) begin
            ch_grant = 1'b1;
            sel      = int'(pick.idx);
        end
        if (ch_grant) begin
            grant_vld   = 1'b1;
            ch_pop[sel] = 1'b1;
            grant_req   = ch_head[sel];
            rr_ptr_nxt  = 3'((sel + 1) % NCH);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_ptr   <= '0;
            rdWe_o   <= 1'b0;
            rdId_o   <= '0;
            rdData_o <= '0;
            retire_o <= 1'b0;
        end else begin
            rr_ptr   <= rr_ptr_nxt;
            retire_o <= ~MW_nop_i & ~stall;
            rdWe_o   <= grant_vld & (grant_req.rd_id != '0);
            if (grant_vld) begin
                rdId_o   <= grant_req.rd_id;
                rdData_o <= XLEN'(grant_req.data);
            end
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            instret_o <= '0;
        end else if (instretLoad_i) begin
            instret_o <= instretData_i;
        end else if (retire_o) begin
            instret_o <= instret_o + 64'd1;
        end
    end
`endif

endmodule
